// File: rtl/clkgen_multi.sv
`timescale 1ns/1ps
// clkgen_multi: multi-channel integer clock divider with glitch-free reconfiguration and lock flag.
// Per-channel start-phase offsets are built only when CLKGEN_PHASE_EN is defined.
module clkgen_multi #(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8,
    parameter int DEF_DIV     = 40,
    parameter int LOCK_CYCLES = 64
) (
    input  logic                    clkin,
    input  logic                    rst_n,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [NUM_CH*DIV_W-1:0] cfg_div,
    input  logic [NUM_CH*DIV_W-1:0] cfg_phase,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       clk_en,
    output logic                    lock,
    output logic [1:0]              fsm_state
);

    // cfg handshake: a configuration transfers on any rising edge where cfg_valid && cfg_ready;
    // cfg_valid seen while cfg_ready is low is ignored and must be held by the source.
    typedef enum logic [1:0] {LOCKING = 2'd0, LOCKED = 2'd1, DRAIN = 2'd2} state_t;

    localparam int LW = (LOCK_CYCLES < 2) ? 1 : $clog2(LOCK_CYCLES);
    localparam logic [DIV_W-1:0] DEF_V = (DEF_DIV < 2) ? DIV_W'(2) : DIV_W'(DEF_DIV);

    function automatic logic [DIV_W-1:0] norm_div(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(2)) ? DIV_W'(2) : d;
    endfunction

    function automatic logic [DIV_W:0] half_div(input logic [DIV_W-1:0] d);
        return ({1'b0, d} + (DIV_W+1)'(1)) >> 1;
    endfunction

    state_t            state;
    logic              boot;
    logic [LW-1:0]     lcnt;
    logic [DIV_W-1:0]  div_q   [NUM_CH];
    logic [DIV_W-1:0]  new_div [NUM_CH];
    logic [DIV_W-1:0]  cnt     [NUM_CH];
    logic [NUM_CH-1:0] running;

    logic [DIV_W-1:0]  cnt_n [NUM_CH];
    logic [DIV_W-1:0]  div_n [NUM_CH];
    logic [NUM_CH-1:0] run_n;
    logic [NUM_CH-1:0] out_n;
    logic [NUM_CH-1:0] en_n;
    logic [NUM_CH-1:0] waiting;
    logic              apply;
    logic              hs;
    logic              all_idle;
    logic              draining;

`ifdef CLKGEN_PHASE_EN
    logic [DIV_W-1:0]  wait_q    [NUM_CH];
    logic [DIV_W-1:0]  wait_n    [NUM_CH];
    logic [DIV_W-1:0]  new_phase [NUM_CH];

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            waiting[i] = (wait_q[i] != '0);
        end
    end
`else
    logic unused_phase;
    assign unused_phase = ^cfg_phase;
    assign waiting      = '0;
`endif

    assign draining  = (state == DRAIN);
    assign all_idle  = (running == '0) && (waiting == '0);
    // The reset apply happens on the first edge out of reset; later ones once a drain has emptied.
    assign apply     = boot || (draining && all_idle);
    assign hs        = cfg_valid && cfg_ready;
    assign fsm_state = state;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            run_n[i] = running[i];
            cnt_n[i] = cnt[i];
            div_n[i] = div_q[i];
`ifdef CLKGEN_PHASE_EN
            wait_n[i] = wait_q[i];
`endif
            if (apply) begin
                div_n[i] = new_div[i];
                cnt_n[i] = '0;
`ifdef CLKGEN_PHASE_EN
                wait_n[i] = new_phase[i];
                run_n[i]  = (new_phase[i] == '0);
`else
                run_n[i]  = 1'b1;
`endif
            end else if (running[i]) begin
                // While draining, the period boundary parks the channel low instead of wrapping.
                if (cnt[i] == div_q[i] - DIV_W'(1)) begin
                    cnt_n[i] = '0;
                    run_n[i] = !draining;
                end else begin
                    cnt_n[i] = cnt[i] + DIV_W'(1);
                end
            end
`ifdef CLKGEN_PHASE_EN
            else if (waiting[i]) begin
                wait_n[i] = draining ? '0 : wait_q[i] - DIV_W'(1);
                run_n[i]  = !draining && (wait_q[i] == DIV_W'(1));
            end
`endif
            en_n[i]  = run_n[i] && (cnt_n[i] == '0);
            out_n[i] = run_n[i] && ({1'b0, cnt_n[i]} < half_div(div_n[i]));
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOCKING;
            boot      <= 1'b1;
            lcnt      <= '0;
            cfg_ready <= 1'b0;
            lock      <= 1'b0;
            clk_out   <= '0;
            clk_en    <= '0;
            running   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i]   <= DEF_V;
                new_div[i] <= DEF_V;
                cnt[i]     <= '0;
`ifdef CLKGEN_PHASE_EN
                wait_q[i]    <= '0;
                new_phase[i] <= '0;
`endif
            end
        end else begin
            boot    <= 1'b0;
            running <= run_n;
            clk_out <= out_n;
            clk_en  <= en_n;
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= div_n[i];
                cnt[i]   <= cnt_n[i];
`ifdef CLKGEN_PHASE_EN
                wait_q[i] <= wait_n[i];
`endif
            end
            if (apply) begin
                state     <= LOCKING;
                lcnt      <= '0;
                cfg_ready <= 1'b1;
            end else if (hs) begin
                // A handshake beats a lock count completing on the same edge.
                state     <= DRAIN;
                cfg_ready <= 1'b0;
                lock      <= 1'b0;
                for (int i = 0; i < NUM_CH; i++) begin
                    new_div[i] <= norm_div(cfg_div[i*DIV_W +: DIV_W]);
`ifdef CLKGEN_PHASE_EN
                    new_phase[i] <= cfg_phase[i*DIV_W +: DIV_W];
`endif
                end
            end else if (state == LOCKING) begin
                if (lcnt == LW'(LOCK_CYCLES - 1)) begin
                    state <= LOCKED;
                    lock  <= 1'b1;
                end else begin
                    lcnt <= lcnt + LW'(1);
                end
            end
        end
    end

endmodule
